// File: rtl/mult8x8_seq_ctrl.sv
// Sequencing controller for an 8x8 multiply built from one shared 4x4 multiplier.
// Steps the nibble mux, shifter and accumulator through four partial products.
module mult8x8_seq_ctrl #(
  parameter int unsigned DONE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a_sel,
  output logic       b_sel,
  output logic [1:0] shift_cntrl,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_out,
  output logic       overlap_err
);

  typedef enum logic [2:0] {
    StIdle = 3'b000,
    StCyc0 = 3'b001,
    StCyc1 = 3'b010,
    StCyc2 = 3'b011,
    StCyc3 = 3'b100,
    StDone = 3'b101
  } state_e;

  localparam logic [3:0] HoldLast = 4'(DONE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       overlap_q, overlap_d;
  logic       busy_st;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      overlap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      overlap_q <= overlap_d;
    end
  end

  assign busy_st   = (state_q == StCyc0) || (state_q == StCyc1) ||
                     (state_q == StCyc2) || (state_q == StCyc3);
  // A start seen mid-operation is flagged but never restarts the sequence.
  assign overlap_d = busy_st && start;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: if (start) state_d = StCyc0;
      StCyc0: state_d = StCyc1;
      StCyc1: state_d = StCyc2;
      StCyc2: state_d = StCyc3;
      StCyc3: begin
        state_d = StDone;
        hold_d  = '0;
      end
      StDone: begin
        if (start) begin
          state_d = StCyc0;
        end else if (hold_q == HoldLast) begin
          state_d = StIdle;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs: decoded from the state register only.
  always_comb begin
    a_sel       = 1'b0;
    b_sel       = 1'b0;
    shift_cntrl = 2'b00;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    done        = 1'b0;
    case (state_q)
      StCyc0: begin
        acc_clr = 1'b1;
        acc_en  = 1'b1;
      end
      StCyc1: begin
        b_sel       = 1'b1;
        shift_cntrl = 2'b01;
        acc_en      = 1'b1;
      end
      StCyc2: begin
        a_sel       = 1'b1;
        shift_cntrl = 2'b01;
        acc_en      = 1'b1;
      end
      StCyc3: begin
        a_sel       = 1'b1;
        b_sel       = 1'b1;
        shift_cntrl = 2'b10;
        acc_en      = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy        = busy_st;
  assign state_out   = state_q;
  assign overlap_err = overlap_q;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Directed bench for mult8x8_seq_ctrl: a reference datapath builds the product from the
// control outputs and a scoreboard compares it against the arithmetic product of a and b.
module tb_mult8x8_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, start3;
  logic [7:0] a, b;

  logic       a_sel, b_sel, acc_clr, acc_en, busy, done, overlap_err;
  logic [1:0] shift_cntrl;
  logic [2:0] state_out;

  logic       a_sel3, b_sel3, acc_clr3, acc_en3, busy3, done3, overlap_err3;
  logic [1:0] shift_cntrl3;
  logic [2:0] state_out3;

  int total = 0;
  int bad   = 0;
  int ovl_seen;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mult8x8_seq_ctrl #(.DONE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a_sel(a_sel), .b_sel(b_sel), .shift_cntrl(shift_cntrl),
    .acc_clr(acc_clr), .acc_en(acc_en), .busy(busy), .done(done),
    .state_out(state_out), .overlap_err(overlap_err)
  );

  mult8x8_seq_ctrl #(.DONE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .a_sel(a_sel3), .b_sel(b_sel3), .shift_cntrl(shift_cntrl3),
    .acc_clr(acc_clr3), .acc_en(acc_en3), .busy(busy3), .done(done3),
    .state_out(state_out3), .overlap_err(overlap_err3)
  );

  // Reference datapath: nibble mux, 4x4 multiply, shifter, adder, accumulator.
  logic [3:0]  na, nb;
  logic [15:0] pp, acc;
  always_comb begin
    na = a_sel ? a[7:4] : a[3:0];
    nb = b_sel ? b[7:4] : b[3:0];
    pp = 16'(na) * 16'(nb);
    case (shift_cntrl)
      2'b01:   pp = pp << 4;
      2'b10:   pp = pp << 8;
      default: ;
    endcase
  end
  always @(posedge clk) if (acc_en === 1'b1) acc <= (acc_clr ? 16'h0 : acc) + pp;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {a_sel,b_sel,shift_cntrl,acc_clr,acc_en,busy,done,state_out} per state code.
  function automatic logic [10:0] exp_vec(input logic [2:0] st);
    case (st)
      3'd1:    return {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, st};
      3'd2:    return {1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, st};
      3'd3:    return {1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, st};
      3'd4:    return {1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, st};
      3'd5:    return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, st};
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic [10:0] vec1();
    return {a_sel, b_sel, shift_cntrl, acc_clr, acc_en, busy, done, state_out};
  endfunction

  function automatic logic [10:0] vec3();
    return {a_sel3, b_sel3, shift_cntrl3, acc_clr3, acc_en3, busy3, done3, state_out3};
  endfunction

  function automatic logic [15:0] prod(input logic [7:0] x, input logic [7:0] y);
    return 16'(x) * 16'(y);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare the accumulator on the first cycle of each done pulse.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_empty: observed=done expected=no_done");
      end else begin
        chk("product", acc, exp_q.pop_front());
      end
    end
    done_prev = done;
  end

  // Plain operation with a one-cycle start pulse, checked cycle by cycle.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y);
    a = x;
    b = y;
    exp_q.push_back(prod(x, y));
    start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      chk($sformatf("op_st%0d", s), 16'(vec1()), 16'(exp_vec(3'(s))));
      step();
    end
    chk("op_idle", 16'(vec1()), 16'(exp_vec(3'd0)));
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    a      = '0;
    b      = '0;
    step();
    step();
    chk("rst_vec", 16'(vec1()), 16'(exp_vec(3'd0)));
    chk("rst_ovl", 16'(overlap_err), 16'd0);
    chk("rst_vec3", 16'(vec3()), 16'(exp_vec(3'd0)));
    reset = 1'b0;
    step();
    chk("idle_vec", 16'(vec1()), 16'(exp_vec(3'd0)));

    run_op(8'hFF, 8'hFF);
    run_op(8'd200, 8'd13);
    run_op(8'h00, 8'hA5);

    // Back-to-back: restart from DONE with no IDLE gap.
    a = 8'h05;
    b = 8'h07;
    exp_q.push_back(prod(8'h05, 8'h07));
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("b2b_done", 16'(vec1()), 16'(exp_vec(3'd5)));
    a = 8'h12;
    b = 8'h34;
    exp_q.push_back(16'h03A8);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      chk($sformatf("b2b_st%0d", s), 16'(vec1()), 16'(exp_vec(3'(s))));
      step();
    end
    chk("b2b_idle", 16'(vec1()), 16'(exp_vec(3'd0)));

    // Overlap: start held through CYC3 gives one pulse per busy cycle.
    a = 8'h9C;
    b = 8'h3B;
    exp_q.push_back(prod(8'h9C, 8'h3B));
    ovl_seen = 0;
    start = 1'b1;
    step();
    for (int s = 1; s <= 5; s++) begin
      chk($sformatf("ovl_st%0d", s), 16'(vec1()), 16'(exp_vec(3'(s))));
      chk($sformatf("ovl_pulse%0d", s), 16'(overlap_err), (s == 1) ? 16'd0 : 16'd1);
      if (overlap_err === 1'b1) ovl_seen++;
      if (s == 5) start = 1'b0;
      step();
    end
    chk("ovl_after", 16'(overlap_err), 16'd0);
    chk("ovl_count", 16'(ovl_seen), 16'd4);
    chk("ovl_idle", 16'(vec1()), 16'(exp_vec(3'd0)));

    // Reset in mid-CYC2, held two cycles, then a fresh operation.
    a = 8'h01;
    b = 8'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_cyc2", 16'(vec1()), 16'(exp_vec(3'd3)));
    reset = 1'b1;
    step();
    chk("mid_rst1", 16'(vec1()), 16'(exp_vec(3'd0)));
    step();
    chk("mid_rst2", 16'(vec1()), 16'(exp_vec(3'd0)));
    reset = 1'b0;
    run_op(8'hB7, 8'h6E);

    // DONE_CYCLES=3 instance: done held three cycles, then IDLE.
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      chk($sformatf("d3_st%0d", s), 16'(vec3()), 16'(exp_vec(3'(s))));
      step();
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d3_done%0d", k), 16'(vec3()), 16'(exp_vec(3'd5)));
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d3_idle%0d", k), 16'(vec3()), 16'(exp_vec(3'd0)));
      chk($sformatf("d3_ovl%0d", k), 16'(overlap_err3), 16'd0);
      step();
    end

    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult8x8_seq_ctrl.md
Name: mult8x8_seq_ctrl

Overview:
Sequencing controller for the 8x8 sequential multiplier. It time-shares the single 4x4 multiplier over four cycles. Each cycle it selects an operand nibble pair and programs the 16-bit shifter. It also drives the accumulator clear/enable and exposes a start/busy/done handshake to the host. It contains no arithmetic: it is pure control for the nibble mux, shifter, adder and accumulator register.

Parameters:
DONE_CYCLES, 1, number of cycles the DONE state (and the done output) is held before returning to IDLE; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a new multiply; sampled only in IDLE or DONE.
a_sel  output  1  operand A nibble select: 0 = a[3:0], 1 = a[7:4].
b_sel  output  1  operand B nibble select: 0 = b[3:0], 1 = b[7:4].
shift_cntrl  output  2  shifter control: 00 = no shift, 01 = <<4, 10 = <<8; 11 is never driven.
acc_clr  output  1  accumulator adds to zero instead of its held value this cycle.
acc_en  output  1  accumulator loads the adder result at the end of this cycle.
busy  output  1  high in CYC0..CYC3.
done  output  1  high in DONE; the accumulator holds the final product.
state_out  output  3  state encoding, for debug and seven-segment display.
overlap_err  output  1  one-cycle pulse when start is seen while busy.

Behaviour:
- One clock, clk. Reset is synchronous and active-high. While reset=1 at a rising edge: state <= IDLE, hold counter <= 0.
- After reset all outputs take IDLE values: a_sel=0, b_sel=0, shift_cntrl=00, acc_clr=0, acc_en=0, busy=0, done=0, state_out=000, overlap_err=0.
- Output style: all outputs except overlap_err are Moore, decoded from the state register only, with no combinational path from start.
- overlap_err is a registered pulse, asserted in the cycle after the offending edge.
- States and encodings: IDLE=000, CYC0=001, CYC1=010, CYC2=011, CYC3=100, DONE=101. Codes 110 and 111 go to IDLE on the next edge.
- Per-state outputs, given as a_sel/b_sel/shift_cntrl/acc_clr/acc_en:
  - CYC0: 0/0/00/1/1
  - CYC1: 0/1/01/0/1
  - CYC2: 1/0/01/0/1
  - CYC3: 1/1/10/0/1
  - IDLE and DONE: 0/0/00/0/0
- Transitions:
  - IDLE: start=1 -> CYC0, else stay.
  - CYC0 -> CYC1 -> CYC2 -> CYC3 -> DONE, unconditionally, one state per cycle.
  - DONE: start=1 -> CYC0 (back-to-back operation, no IDLE gap). Otherwise, when the hold counter reaches DONE_CYCLES-1 -> IDLE; otherwise stay and increment the counter.
  - The hold counter clears on every entry to DONE.
- Latency: start sampled at edge N gives CYC0 during cycle N+1 and done=1 from cycle N+5. The accumulator is final at the edge that enters DONE.
- start while busy (CYC0..CYC3): ignored for sequencing, the operation is not restarted, and overlap_err=1 for one cycle. A start that stays high continuously produces one pulse per busy cycle.
- Reset mid-operation: returns to IDLE at the next edge regardless of state; acc_en=0 from that cycle on. The partial accumulator value is don't-care.
- Operand stability: the host holds a and b constant from the start edge through CYC3. The controller does not latch operands.

Test Plan:
- Reset: assert reset for 2 cycles in mid-CYC2 -> next cycle state_out=000, busy=0, acc_en=0, done=0; start=1 afterwards -> CYC0 one cycle later.
- Single op: a=8'hFF, b=8'hFF, pulse start 1 cycle -> per-cycle {a_sel,b_sel,shift_cntrl} = 0,0,00 / 0,1,01 / 1,0,01 / 1,1,10. With a reference datapath model the accumulator reads 16'hFE01 when done=1, which is exactly 5 cycles after the start edge.
- Product check: a=8'd200, b=8'd13 -> 16'd2600. a=8'h00, b=8'hA5 -> 16'h0000. Each run has done high for exactly DONE_CYCLES cycles, then state_out=000.
- Back-to-back: start=1 during DONE with a=8'h12, b=8'h34 -> CYC0 on the next cycle with acc_clr=1, final result 16'h03A8, no IDLE cycle in between.
- Overlap: start held high from CYC0 through CYC3 -> exactly 4 overlap_err pulses, the sequence is unaltered, and the result is still correct.
- DONE_CYCLES=3: single op -> done high for 3 consecutive cycles, then IDLE. start=0 throughout -> stays in IDLE with all outputs at their IDLE values.
